// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score keeper / BCD converter.
package score_pkg;
  localparam int SCORE_MAX  = 999999;
  localparam int BIN_W_DEF  = 20;
  localparam int DIGITS_DEF = 6;
  localparam int ADD_W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/score_bcd_seq.sv
// Saturating score keeper with a shared sequential double-dabble BCD converter.
// Optional SCORE_LEADING_ZERO_BLANK_EN: registered leading-zero blank mask.
module score_bcd_seq
  import score_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int ADD_W  = ADD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  add_valid,
  input  logic [ADD_W-1:0]      add_value,
  output logic                  add_ready,
  input  logic                  clear,
  output logic [BIN_W-1:0]      score,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic                  digits_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [BIN_W-1:0]           score_q, bin_q;
  logic [DIGITS-1:0][3:0]     acc_q, adj, bcd_q;
  logic                       dvalid_q, ovf_q, accept, sat;
  logic [BIN_W:0]             sum;

  assign add_ready    = (state_q == IDLE) && !clear;
  assign accept       = add_valid && add_ready;
  assign busy         = (state_q != IDLE);
  assign score        = score_q;
  assign bcd_digits   = bcd_q;
  assign digits_valid = dvalid_q;
  assign overflow     = ovf_q;

  assign sum = {1'b0, score_q} + (BIN_W+1)'(add_value);
  assign sat = (sum > (BIN_W+1)'(SCORE_MAX));

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_adjust u_adj (.din(acc_q[d]), .dout(adj[d]));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // clear restarts the conversion from any state, aborting one in flight
    if (clear) state_d = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q  <= '0;
      ovf_q    <= 1'b0;
      dvalid_q <= 1'b1;
      bin_q    <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (clear) begin
        score_q  <= '0;
        ovf_q    <= 1'b0;
        dvalid_q <= 1'b0;
      end else if (accept) begin
        score_q  <= sat ? BIN_W'(SCORE_MAX) : sum[BIN_W-1:0];
        if (sat) ovf_q <= 1'b1;
        dvalid_q <= 1'b0;
      end
      unique case (state_q)
        LOAD: begin
          bin_q <= score_q;
          acc_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          {acc_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
        end
        // a clear landing on DONE would publish digits of the old score
        DONE: if (!clear) begin
          bcd_q    <= acc_q;
          dvalid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] mask_d, mask_q;
  logic              hi_zero;

  always_comb begin
    mask_d  = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero   = hi_zero && (acc_q[i] == 4'd0);
      mask_d[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           mask_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (state_q == DONE && !clear)   mask_q <= mask_d;
  end

  assign blank_mask = mask_q;
`else
  assign blank_mask = '0;
`endif
endmodule

// File: tb/tb_score_bcd_seq.sv
// Directed bench for score_bcd_seq: handshake, latency, saturation, clear and blank mask.
module tb_score_bcd_seq;
  logic        clk, rst_n, add_valid, add_ready, clear;
  logic [19:0] add_value, score;
  logic [23:0] bcd_digits;
  logic        digits_valid, busy, overflow;
  logic [5:0]  blank_mask;
  int          npass = 0, ntot = 0, nacc;
  logic        saw456;

  score_bcd_seq #(.BIN_W(20), .DIGITS(6), .ADD_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_value(add_value),
    .add_ready(add_ready), .clear(clear), .score(score), .bcd_digits(bcd_digits),
    .digits_valid(digits_valid), .busy(busy), .overflow(overflow), .blank_mask(blank_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] mx(input logic [5:0] m);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    return m;
`else
    return 6'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Waits (bounded) for ready, presents one add across one accept edge.
  task automatic do_add(input logic [19:0] v);
    int k = 0;
    while (!add_ready && k < 50) begin step(); k++; end
    chk("ready_wait", {31'b0, add_ready}, 32'd1);
    add_valid = 1'b1;
    add_value = v;
    step();
    add_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; add_valid = 1'b0; add_value = '0; clear = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_bcd",    bcd_digits,   24'h000000);
    chk("rst_dvalid", digits_valid, 1);
    chk("rst_ready",  add_ready,    1);
    chk("rst_ovf",    overflow,     0);
    chk("rst_busy",   busy,         0);
    chk("rst_score",  score,        0);
    chk("rst_mask",   blank_mask,   mx(6'b111110));
    step(2);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", add_ready, 1);

    // add 123: exact 22-cycle latency from accept edge
    do_add(20'd123);
    chk("a123_ready_low", add_ready,    0);
    chk("a123_busy",      busy,         1);
    chk("a123_dv_low",    digits_valid, 0);
    chk("a123_score",     score,        123);
    step(21);
    chk("a123_not_yet",   bcd_digits,   24'h000000);
    chk("a123_dv_21",     digits_valid, 0);
    step();
    chk("a123_bcd",       bcd_digits,   24'h000123);
    chk("a123_dv",        digits_valid, 1);
    chk("a123_idle",      busy,         0);
    chk("a123_mask",      blank_mask,   mx(6'b111000));

    // bring score to 999990, then saturate
    do_add(20'd999867);
    step(22);
    chk("pre_score", score,      999990);
    chk("pre_bcd",   bcd_digits, 24'h999990);
    chk("pre_ovf",   overflow,   0);
    do_add(20'd15);
    chk("sat_score", score,    999999);
    chk("sat_ovf",   overflow, 1);
    step(22);
    chk("sat_bcd",   bcd_digits, 24'h999999);
    chk("sat_mask",  blank_mask, mx(6'b000000));

    // add of 0 at saturation still converts
    do_add(20'd0);
    chk("add0_busy",  busy,         1);
    chk("add0_dv",    digits_valid, 0);
    chk("add0_score", score,        999999);
    step(22);
    chk("add0_bcd",   bcd_digits,   24'h999999);
    chk("add0_ovf",   overflow,     1);

    // clear from idle
    clear = 1'b1;
    #1 chk("clr_ready_low", add_ready, 0);
    step();
    clear = 1'b0;
    chk("clr_score", score,        0);
    chk("clr_ovf",   overflow,     0);
    chk("clr_dv",    digits_valid, 0);
    step(22);
    chk("clr_bcd",   bcd_digits,   24'h000000);
    chk("clr_dv2",   digits_valid, 1);
    chk("clr_mask",  blank_mask,   mx(6'b111110));

    // clear during SHIFT iteration 10 of a 456 conversion
    do_add(20'd456);
    step(11);
    clear = 1'b1;
    step();
    clear = 1'b0;
    saw456 = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (bcd_digits == 24'h000456) saw456 = 1'b1;
      step();
    end
    chk("abort_no456", saw456,       0);
    chk("abort_bcd",   bcd_digits,   24'h000000);
    chk("abort_dv",    digits_valid, 1);
    chk("abort_score", score,        0);

    // add_valid held with value 1 for 100 cycles
    nacc = 0;
    add_valid = 1'b1;
    add_value = 20'd1;
    for (int i = 0; i < 100; i++) begin
      if (add_ready) nacc++;
      step();
    end
    add_valid = 1'b0;
    chk("hold_accepts", nacc,  5);
    chk("hold_score",   score, 5);
    step(15);
    chk("hold_bcd",     bcd_digits,   24'h000005);
    chk("hold_dv",      digits_valid, 1);

    // clear beats a simultaneous add
    add_valid = 1'b1;
    add_value = 20'd7;
    clear     = 1'b1;
    step();
    add_valid = 1'b0;
    clear     = 1'b0;
    chk("clr_add_score", score, 0);
    step(22);
    chk("clr_add_bcd",   bcd_digits, 24'h000000);

    // 1203: middle zero digit must not be blanked
    do_add(20'd1203);
    step(22);
    chk("b1203_bcd",  bcd_digits, 24'h001203);
    chk("b1203_mask", blank_mask, mx(6'b110000));

    // reset mid-conversion returns to reset values
    do_add(20'd77);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_score", score,        0);
    chk("mid_rst_bcd",   bcd_digits,   24'h000000);
    chk("mid_rst_dv",    digits_valid, 1);
    chk("mid_rst_busy",  busy,         0);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
